cpu_regfile: RTL and testbench
==============================

Name: cpu_regfile

Overview:
- Parametrised successor to the single CPU data register: a bank of NUM_REGS general registers of DATA_W bits, driven by the same 3-bit command style.
- Loads from and stores to the shared tri-state data bus, feeds two ALU operands, writes back ALU results, and drives the bus address.
- Adds increment, register-to-register move and an optional hardwired-zero R0.
- Sits between the CPU control FSM (source of cmd/sel) and the data bus / ALU.

Parameters:
- DATA_W, 8, register, bus, ALU and address width in bits.
- NUM_REGS, 4, number of registers; must be 2 or more.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_REGS.
- ZERO_R0, 0, when 1, R0 always reads 0 and ignores all writes.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- cmd  in  3  operation for this cycle; sampled at posedge CLK.
- sel_a  in  SEL_W  destination / first source register.
- sel_b  in  SEL_W  second source register (TO_ALU, MOV).
- BUS_DATA  inout  DATA_W  shared tri-state data bus.
- BUS_ADDR  out  DATA_W  registered bus address.
- ALU_A  out  DATA_W  registered ALU operand A.
- ALU_B  out  DATA_W  registered ALU operand B.
- ALU_VALID  out  1  one-cycle pulse: ALU_A/ALU_B updated.
- ALU_RESULT  in  DATA_W  ALU result for write-back.
- BUS_OE  out  1  high while this block drives BUS_DATA.

Behaviour:
- Reset: one clock CLK; reset RESET_N is asynchronous and active-low. While RESET_N=0:
  - all registers, BUS_ADDR, ALU_A, ALU_B = 0
  - ALU_VALID = 0, BUS_OE = 0
  - BUS_DATA = Z immediately, not waiting for a clock edge; this applies to reset asserted mid-store as well.
- Commands (sampled at posedge; effects visible after that edge):
  - 000 NOP: no change.
  - 001 LOAD_BUS: R[sel_a] <= BUS_DATA.
  - 010 STORE_BUS: BUS_OE <= 1 and the drive register <= R[sel_a]. BUS_DATA carries the value for exactly the next cycle. BUS_OE drops at the next edge unless cmd is STORE_BUS again (back-to-back stores drive continuously, with the data updated).
  - 011 TO_ALU: ALU_A <= R[sel_a], ALU_B <= R[sel_b], ALU_VALID <= 1 for one cycle. The operands hold until the next TO_ALU.
  - 100 TO_ADDR: BUS_ADDR <= R[sel_a]; holds until the next TO_ADDR.
  - 101 LOAD_ALU: R[sel_a] <= ALU_RESULT.
  - 110 INC: R[sel_a] <= R[sel_a] + 1, modulo 2**DATA_W (all-ones wraps to 0, no carry out).
  - 111 MOV: R[sel_a] <= R[sel_b]; sel_a == sel_b is a no-op.
- Latency: every read result (bus, ALU, address) is registered, so it is valid 1 cycle after the command edge. A write followed next cycle by a read of the same register returns the new value; no bypass is needed.
- Outputs other than BUS_DATA are flops; BUS_DATA = BUS_OE ? drive register : Z.
- Out-of-range select (sel >= NUM_REGS):
  - a write is ignored
  - a read returns 0.
- ZERO_R0 = 1:
  - R0 reads 0
  - writes to R0 are ignored, including INC and MOV.
- LOAD_BUS while BUS_OE = 1 (the block's own previous store): the register loads the value this block is driving. This is legal and must not create X.
- Only one command per cycle, so there is no write-write conflict.

Decomposition:
- Shared package cpu_pkg holds the command encodings as named localparams: CMD_NOP, CMD_LOAD_BUS, CMD_STORE_BUS, CMD_TO_ALU, CMD_TO_ADDR, CMD_LOAD_ALU, CMD_INC, CMD_MOV. The existing single-register block and the control FSM share it.
- No sub-module: storage array, decode and output flops stay in one module.

Test Plan:
- Reset / LOAD / STORE: release RESET_N, drive bus 8'h1A, LOAD_BUS sel_a=2, then STORE_BUS sel_a=2 -> BUS_OE=1 and BUS_DATA=8'h1A in the following cycle only; Z afterwards; all outputs 0 during reset.
- TO_ALU / write-back: R1=8'h05, R3=8'hF0, TO_ALU a=1 b=3 -> ALU_A=05, ALU_B=F0, ALU_VALID single pulse; ALU_RESULT=8'h77, LOAD_ALU sel_a=0 -> R0=77 (ZERO_R0=0).
- INC wrap / MOV: R2=8'hFF, INC sel_a=2 -> R2=00; MOV a=1 b=2 then TO_ADDR sel_a=1 -> BUS_ADDR=00.
- ZERO_R0=1 build: LOAD_BUS 8'hAA into R0, then TO_ALU a=0 b=0 -> ALU_A=ALU_B=00; out-of-range select read (NUM_REGS=3, sel=3) -> 00.
- Back-to-back stores: STORE R1 (8'h11), STORE R2 (8'h22) -> BUS_OE high for 2 cycles, data 11 then 22, no Z glitch between them.
- Reset mid-operation: assert RESET_N low halfway through a STORE_BUS drive cycle -> BUS_DATA goes Z and BUS_OE=0 immediately, all registers read 0 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: 3-bit command encodings used by the control FSM,
// the single data register and the register file.
package cpu_pkg;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_NOP       = 3'b000;
    localparam cmd_t CMD_LOAD_BUS  = 3'b001;
    localparam cmd_t CMD_STORE_BUS = 3'b010;
    localparam cmd_t CMD_TO_ALU    = 3'b011;
    localparam cmd_t CMD_TO_ADDR   = 3'b100;
    localparam cmd_t CMD_LOAD_ALU  = 3'b101;
    localparam cmd_t CMD_INC       = 3'b110;
    localparam cmd_t CMD_MOV       = 3'b111;

endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: bank of NUM_REGS registers of DATA_W bits, driven by a 3-bit
// command per cycle.
// Ports:
//   CLK, RESET_N    clock, asynchronous active-low reset
//   cmd             operation (cpu_pkg::CMD_*)
//   sel_a, sel_b    destination/first source, second source
//   BUS_DATA        shared tri-state data bus (load source / store target)
//   BUS_ADDR        registered bus address (TO_ADDR)
//   ALU_A, ALU_B    registered ALU operands (TO_ALU)
//   ALU_VALID       one-cycle pulse after TO_ALU
//   ALU_RESULT      write-back value (LOAD_ALU)
//   BUS_OE          high while this block drives BUS_DATA
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 2,
    parameter int ZERO_R0  = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [2:0]        cmd,
    input  logic [SEL_W-1:0]  sel_a,
    input  logic [SEL_W-1:0]  sel_b,
    inout  wire  [DATA_W-1:0] BUS_DATA,
    output logic [DATA_W-1:0] BUS_ADDR,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic              ALU_VALID,
    input  logic [DATA_W-1:0] ALU_RESULT,
    output logic              BUS_OE
);

    localparam int NSEL = 1 << SEL_W;

    if (NUM_REGS < 2 || NSEL < NUM_REGS) begin : g_bad_params
        $error("cpu_regfile: need NUM_REGS >= 2 and 2**SEL_W >= NUM_REGS");
    end

    // Read view covering every select code. Codes without a real register
    // (out of range, or R0 when hardwired) read 0, and since they have no
    // storage, writes to them vanish.
    logic [DATA_W-1:0] rd_arr [NSEL];
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              wen;
    logic [DATA_W-1:0] wdata;

    assign rd_a = rd_arr[sel_a];
    assign rd_b = rd_arr[sel_b];

    // Write-back source select; one command per cycle, so one write port.
    always_comb begin
        wen   = 1'b1;
        wdata = '0;
        case (cmd)
            CMD_LOAD_BUS: wdata = BUS_DATA;
            CMD_LOAD_ALU: wdata = ALU_RESULT;
            CMD_INC:      wdata = rd_a + DATA_W'(1);
            CMD_MOV:      wdata = rd_b;
            default:      wen   = 1'b0;
        endcase
    end

    for (genvar g = 0; g < NSEL; g++) begin : g_reg
        if (g < NUM_REGS && !(ZERO_R0 != 0 && g == 0)) begin : g_store
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N)
                    r_q <= '0;
                else if (wen && sel_a == SEL_W'(g))
                    r_q <= wdata;
            end
            assign rd_arr[g] = r_q;
        end else begin : g_zero
            assign rd_arr[g] = '0;
        end
    end

    logic [DATA_W-1:0] addr_q, alu_a_q, alu_b_q, drv_q;
    logic              alu_vld_q, oe_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            addr_q    <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            drv_q     <= '0;
            alu_vld_q <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            alu_vld_q <= (cmd == CMD_TO_ALU);
            oe_q      <= (cmd == CMD_STORE_BUS);
            if (cmd == CMD_STORE_BUS) drv_q <= rd_a;
            if (cmd == CMD_TO_ADDR)   addr_q <= rd_a;
            if (cmd == CMD_TO_ALU) begin
                alu_a_q <= rd_a;
                alu_b_q <= rd_b;
            end
        end
    end

    assign BUS_ADDR  = addr_q;
    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_VALID = alu_vld_q;
    assign BUS_OE    = oe_q;

    // oe_q clears asynchronously on reset, so the bus releases at once.
    assign BUS_DATA = oe_q ? drv_q : 'z;

endmodule

// File: tb/tb_cpu_regfile.sv
module tb_cpu_regfile;
    import cpu_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [2:0] cmd;
    logic [1:0] sel_a, sel_b;
    logic [7:0] ALU_RESULT;
    logic [7:0] tb_bus;
    logic       tb_oe;

    wire  [7:0] bus0, bus1;
    logic [7:0] addr0, addr1, aa0, aa1, ab0, ab1;
    logic       vld0, vld1, oe0, oe1;

    assign bus0 = tb_oe ? tb_bus : 'z;
    assign bus1 = tb_oe ? tb_bus : 'z;

    always #5 CLK = ~CLK;

    // Instance 0: default build. Instance 1: 3 registers, hardwired R0.
    cpu_regfile #(.DATA_W(8), .NUM_REGS(4), .SEL_W(2), .ZERO_R0(0)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .cmd(cmd), .sel_a(sel_a), .sel_b(sel_b),
        .BUS_DATA(bus0), .BUS_ADDR(addr0), .ALU_A(aa0), .ALU_B(ab0),
        .ALU_VALID(vld0), .ALU_RESULT(ALU_RESULT), .BUS_OE(oe0));

    cpu_regfile #(.DATA_W(8), .NUM_REGS(3), .SEL_W(2), .ZERO_R0(1)) dut_z (
        .CLK(CLK), .RESET_N(RESET_N), .cmd(cmd), .sel_a(sel_a), .sel_b(sel_b),
        .BUS_DATA(bus1), .BUS_ADDR(addr1), .ALU_A(aa1), .ALU_B(ab1),
        .ALU_VALID(vld1), .ALU_RESULT(ALU_RESULT), .BUS_OE(oe1));

    // Reference model: plain register arrays plus expected output values.
    int         n_tests = 0;
    int         n_fail  = 0;
    int         nregs [2] = '{4, 3};
    bit         zr0   [2] = '{1'b0, 1'b1};
    logic [7:0] mr    [2][4];
    logic [7:0] maddr [2], ma [2], mb [2], mdrv [2];
    logic       mv    [2], moe [2];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mrd(input int i, input int s);
        if (s >= nregs[i] || (zr0[i] && s == 0)) return 8'h00;
        return mr[i][s];
    endfunction

    task automatic mwr(input int i, input int s, input logic [7:0] v);
        if (s < nregs[i] && !(zr0[i] && s == 0)) mr[i][s] = v;
    endtask

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 4; r++) mr[i][r] = 8'h00;
            maddr[i] = 0; ma[i] = 0; mb[i] = 0; mdrv[i] = 0; mv[i] = 0; moe[i] = 0;
        end
    endtask

    task automatic mupd(input int i, input logic [2:0] c, input int a, input int b,
                        input logic [7:0] bv, input logic [7:0] ar);
        logic [7:0] ra, rb, ld;
        ra = mrd(i, a);
        rb = mrd(i, b);
        ld = moe[i] ? mdrv[i] : bv;   // own store wins the bus
        mv[i]  = 1'b0;
        moe[i] = 1'b0;
        case (c)
            CMD_LOAD_BUS:  mwr(i, a, ld);
            CMD_STORE_BUS: begin moe[i] = 1'b1; mdrv[i] = ra; end
            CMD_TO_ALU:    begin ma[i] = ra; mb[i] = rb; mv[i] = 1'b1; end
            CMD_TO_ADDR:   maddr[i] = ra;
            CMD_LOAD_ALU:  mwr(i, a, ar);
            CMD_INC:       mwr(i, a, ra + 8'd1);
            CMD_MOV:       mwr(i, a, rb);
            default:       ;
        endcase
    endtask

    task automatic cmp(input int i, input logic [7:0] addr, input logic [7:0] a,
                       input logic [7:0] b, input logic v, input logic oe,
                       input logic [7:0] bus);
        chk($sformatf("oe%0d", i),   {7'd0, oe}, {7'd0, moe[i]});
        chk($sformatf("vld%0d", i),  {7'd0, v},  {7'd0, mv[i]});
        chk($sformatf("alu_a%0d", i), a, ma[i]);
        chk($sformatf("alu_b%0d", i), b, mb[i]);
        chk($sformatf("addr%0d", i), addr, maddr[i]);
        if (moe[i]) chk($sformatf("bus%0d", i), bus, mdrv[i]);
    endtask

    task automatic cmp_all();
        cmp(0, addr0, aa0, ab0, vld0, oe0, bus0);
        cmp(1, addr1, aa1, ab1, vld1, oe1, bus1);
    endtask

    // One command: inputs set at negedge, model advanced at posedge,
    // outputs checked 1 time unit later.
    task automatic step(input logic [2:0] c, input int a, input int b,
                        input logic [7:0] bv, input logic [7:0] ar);
        @(negedge CLK);
        cmd = c; sel_a = 2'(a); sel_b = 2'(b);
        ALU_RESULT = ar; tb_bus = bv;
        tb_oe = (c == CMD_LOAD_BUS) && !moe[0];
        @(posedge CLK);
        mupd(0, c, a, b, bv, ar);
        mupd(1, c, a, b, bv, ar);
        #1;
        cmp_all();
    endtask

    initial begin
        RESET_N = 1'b0; cmd = CMD_NOP; sel_a = 0; sel_b = 0;
        ALU_RESULT = 0; tb_bus = 0; tb_oe = 0;
        mreset();
        #22;
        cmp_all();                              // all outputs 0 in reset
        @(negedge CLK); RESET_N = 1'b1;

        // Load / store
        step(CMD_LOAD_BUS, 2, 0, 8'h1A, 0);
        step(CMD_STORE_BUS, 2, 0, 0, 0);
        chk("st_oe", {7'd0, oe0}, 8'd1);
        chk("st_data", bus0, 8'h1A);
        step(CMD_NOP, 0, 0, 0, 0);
        chk("st_off", {7'd0, oe0}, 8'd0);

        // TO_ALU / write-back
        step(CMD_LOAD_BUS, 1, 0, 8'h05, 0);
        step(CMD_LOAD_BUS, 3, 0, 8'hF0, 0);
        step(CMD_TO_ALU, 1, 3, 0, 0);
        chk("alu_a_05", aa0, 8'h05);
        chk("alu_b_f0", ab0, 8'hF0);
        step(CMD_NOP, 0, 0, 0, 0);
        chk("vld_pulse", {7'd0, vld0}, 8'd0);
        step(CMD_LOAD_ALU, 0, 0, 0, 8'h77);
        step(CMD_TO_ALU, 0, 0, 0, 0);
        chk("r0_77", aa0, 8'h77);
        chk("zr0_a", aa1, 8'h00);

        // INC wrap / MOV / TO_ADDR
        step(CMD_LOAD_BUS, 2, 0, 8'hFF, 0);
        step(CMD_INC, 2, 0, 0, 0);
        step(CMD_MOV, 1, 2, 0, 0);
        step(CMD_TO_ADDR, 1, 0, 0, 0);
        chk("addr_wrap", addr0, 8'h00);

        // Hardwired R0 and out-of-range select on instance 1
        step(CMD_LOAD_BUS, 0, 0, 8'hAA, 0);
        step(CMD_LOAD_BUS, 1, 0, 8'h3C, 0);
        step(CMD_LOAD_BUS, 3, 0, 8'h5A, 0);
        step(CMD_TO_ALU, 3, 1, 0, 0);
        chk("oor_read", aa1, 8'h00);
        chk("oor_b", ab1, 8'h3C);

        // Back-to-back stores, then load from own drive
        step(CMD_LOAD_BUS, 1, 0, 8'h11, 0);
        step(CMD_LOAD_BUS, 2, 0, 8'h22, 0);
        step(CMD_STORE_BUS, 1, 0, 0, 0);
        chk("b2b_d1", bus0, 8'h11);
        step(CMD_STORE_BUS, 2, 0, 0, 0);
        chk("b2b_oe", {7'd0, oe0}, 8'd1);
        chk("b2b_d2", bus0, 8'h22);
        step(CMD_LOAD_BUS, 3, 0, 8'hEE, 0);     // loads own 22, not EE
        step(CMD_TO_ALU, 3, 0, 0, 0);
        chk("self_load", aa0, 8'h22);

        // Randomized traffic
        for (int k = 0; k < 600; k++)
            step(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));

        // Reset in the middle of a store drive cycle
        step(CMD_LOAD_BUS, 2, 0, 8'h9C, 0);
        step(CMD_STORE_BUS, 2, 0, 0, 0);
        #3 RESET_N = 1'b0;
        #1;
        chk("rst_oe0", {7'd0, oe0}, 8'd0);
        chk("rst_oe1", {7'd0, oe1}, 8'd0);
        mreset();
        cmp_all();
        @(negedge CLK); RESET_N = 1'b1;
        step(CMD_TO_ALU, 2, 1, 0, 0);
        chk("rst_r2", aa0, 8'h00);
        step(CMD_TO_ALU, 3, 0, 0, 0);
        chk("rst_r3", aa0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
